dma_bus_arbiter: RTL and testbench

- Word-copy DMA engine plus a two-master arbiter for the SoC data bus.
- Sits between the pipelined CPU data port and the top-level address decoder / read mux, so DMA traffic reaches RAM, VRAM, palette and audio exactly like CPU traffic.
- The CPU programs source, destination and length through a small register file, then starts a transfer.
- The block interleaves DMA accesses with CPU accesses and raises an interrupt on completion.

---
 rtl/dma_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_bus_arbiter
// Description : Word-copy DMA engine sharing the SoC data bus with the CPU
//               through a starvation-limited two-master arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int LEN_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wenable,
    output logic        cpu_stall,
    input  logic        cfg_wenable,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wenable,
    input  logic [31:0] bus_rdata,
    output logic        dma_irq
);

    localparam int              c_SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SW-1:0] c_LIMIT = c_SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_RD   = 2'd1,
        c_CAP  = 2'd2,
        c_WR   = 2'd3
    } state_t;

    state_t            r_state_q,   w_state_d;
    logic [31:0]       r_cfg_src_q, w_cfg_src_d;
    logic [31:0]       r_cfg_dst_q, w_cfg_dst_d;
    logic [LEN_W-1:0]  r_cfg_len_q, w_cfg_len_d;
    logic [31:0]       r_src_q,     w_src_d;
    logic [31:0]       r_dst_q,     w_dst_d;
    logic [LEN_W-1:0]  r_count_q,   w_count_d;
    logic [31:0]       r_buf_q,     w_buf_d;
    logic [c_SW-1:0]   r_starve_q,  w_starve_d;
    logic              r_done_q,    w_done_d;
    logic              r_irq_q,     w_irq_d;

    logic w_dma_req;
    logic w_dma_gnt;
    logic w_ctrl_wr;

    always_comb begin
        w_dma_req = (r_state_q == c_RD) || (r_state_q == c_WR);
        w_dma_gnt = w_dma_req && (!cpu_req || (r_starve_q == c_LIMIT));
        cpu_stall = cpu_req && w_dma_gnt;
        if (w_dma_gnt) begin
            bus_addr    = (r_state_q == c_RD) ? r_src_q : r_dst_q;
            bus_wdata   = r_buf_q;
            bus_wenable = (r_state_q == c_WR) ? 4'b1111 : 4'b0000;
        end else begin
            bus_addr    = cpu_addr;
            bus_wdata   = cpu_wdata;
            bus_wenable = cpu_wenable;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_cfg_src_d = r_cfg_src_q;
        w_cfg_dst_d = r_cfg_dst_q;
        w_cfg_len_d = r_cfg_len_q;
        w_src_d     = r_src_q;
        w_dst_d     = r_dst_q;
        w_count_d   = r_count_q;
        w_buf_d     = r_buf_q;
        w_done_d    = r_done_q;
        w_irq_d     = 1'b0;
        w_ctrl_wr   = cfg_wenable && (cfg_addr == 2'd3);

        // A CTRL write clears done; a completion below overrides the clear.
        if (w_ctrl_wr) begin
            w_done_d = 1'b0;
        end

        case (r_state_q)
            c_IDLE: begin
                if (cfg_wenable) begin
                    case (cfg_addr)
                        2'd0:    w_cfg_src_d = {cfg_wdata[31:2], 2'b00};
                        2'd1:    w_cfg_dst_d = {cfg_wdata[31:2], 2'b00};
                        2'd2:    w_cfg_len_d = cfg_wdata[LEN_W-1:0];
                        default: ;
                    endcase
                end
                if (w_ctrl_wr && cfg_wdata[0]) begin
                    if (r_cfg_len_q != '0) begin
                        w_src_d   = r_cfg_src_q;
                        w_dst_d   = r_cfg_dst_q;
                        w_count_d = r_cfg_len_q;
                        w_state_d = c_RD;
                    end else begin
                        w_done_d = 1'b1;
                        w_irq_d  = 1'b1;
                    end
                end
            end
            c_RD: begin
                if (w_dma_gnt) begin
                    w_state_d = c_CAP;
                end
            end
            c_CAP: begin
                w_buf_d   = bus_rdata;
                w_state_d = c_WR;
            end
            default: begin
                if (w_dma_gnt) begin
                    w_src_d   = r_src_q + 32'd4;
                    w_dst_d   = r_dst_q + 32'd4;
                    w_count_d = r_count_q - LEN_W'(1);
                    if (r_count_q == LEN_W'(1)) begin
                        w_state_d = c_IDLE;
                        w_done_d  = 1'b1;
                        w_irq_d   = 1'b1;
                    end else begin
                        w_state_d = c_RD;
                    end
                end
            end
        endcase

        if (w_dma_req && !w_dma_gnt) begin
            w_starve_d = (r_starve_q == c_LIMIT) ? r_starve_q : r_starve_q + c_SW'(1);
        end else begin
            w_starve_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= c_IDLE;
            r_cfg_src_q <= '0;
            r_cfg_dst_q <= '0;
            r_cfg_len_q <= '0;
            r_src_q     <= '0;
            r_dst_q     <= '0;
            r_count_q   <= '0;
            r_buf_q     <= '0;
            r_starve_q  <= '0;
            r_done_q    <= 1'b0;
            r_irq_q     <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cfg_src_q <= w_cfg_src_d;
            r_cfg_dst_q <= w_cfg_dst_d;
            r_cfg_len_q <= w_cfg_len_d;
            r_src_q     <= w_src_d;
            r_dst_q     <= w_dst_d;
            r_count_q   <= w_count_d;
            r_buf_q     <= w_buf_d;
            r_starve_q  <= w_starve_d;
            r_done_q    <= w_done_d;
            r_irq_q     <= w_irq_d;
        end
    end

    assign dma_irq = r_irq_q;

    // SRC/DST/LEN reads expose the live working pointers and remaining count.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            2'd0:    cfg_rdata = r_src_q;
            2'd1:    cfg_rdata = r_dst_q;
            2'd2:    cfg_rdata[LEN_W-1:0] = r_count_q;
            default: cfg_rdata = {30'd0, r_done_q, (r_state_q != c_IDLE)};
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_bus_arbiter
// Description : Directed bench for dma_bus_arbiter with an operation-queue
//               reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_bus_arbiter;

    localparam int c_GAP_OP = 0;
    localparam int c_RD_OP  = 1;
    localparam int c_WR_OP  = 2;
    localparam int c_LIMIT  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wenable;
    logic        cpu_stall;
    logic        cfg_wenable;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wenable;
    logic [31:0] bus_rdata;
    logic        dma_irq;

    dma_bus_arbiter #(.STARVE_LIMIT(4), .LEN_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wenable(cpu_wenable), .cpu_stall(cpu_stall),
        .cfg_wenable(cfg_wenable), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wenable(bus_wenable),
        .bus_rdata(bus_rdata), .dma_irq(dma_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous-read memory on the shared bus
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h5A00_0000 | i;
            bus_rdata <= 32'h0;
        end else begin
            bus_rdata <= mem[bus_addr[11:2]];
            for (int b = 0; b < 4; b++)
                if (bus_wenable[b]) mem[bus_addr[11:2]][8*b +: 8] <= bus_wdata[8*b +: 8];
        end
    end

    // Reference model: a queue of pending DMA operations built at start
    typedef struct {
        int          kind;
        logic [31:0] addr;
    } op_t;

    op_t         q[$];
    logic [31:0] m_src, m_dst, m_buf;
    logic [15:0] m_len;
    logic        m_done, m_irq;
    int          m_streak;

    function automatic logic m_req();
        return (q.size() != 0) && (q[0].kind != c_GAP_OP);
    endfunction

    function automatic logic m_gnt();
        return m_req() && (!cpu_req || (m_streak >= c_LIMIT));
    endfunction

    always @(posedge clk) begin
        logic g, r, nirq;
        op_t  op;
        if (rst) begin
            q.delete();
            m_src = 0; m_dst = 0; m_len = 0; m_buf = 0;
            m_done = 0; m_irq = 0; m_streak = 0;
        end else begin
            g = m_gnt();
            r = m_req();
            nirq = 0;
            if (cfg_wenable && cfg_addr == 2'd3) m_done = 0;
            if (q.size() != 0) begin
                op = q[0];
                if (op.kind == c_GAP_OP) begin
                    void'(q.pop_front());
                end else if (g) begin
                    if (op.kind == c_RD_OP) m_buf = mem[op.addr[11:2]];
                    void'(q.pop_front());
                    if (op.kind == c_WR_OP && q.size() == 0) begin
                        m_done = 1; nirq = 1;
                    end
                end
            end else if (cfg_wenable) begin
                case (cfg_addr)
                    2'd0: m_src = {cfg_wdata[31:2], 2'b00};
                    2'd1: m_dst = {cfg_wdata[31:2], 2'b00};
                    2'd2: m_len = cfg_wdata[15:0];
                    default: if (cfg_wdata[0]) begin
                        if (m_len == 0) begin
                            m_done = 1; nirq = 1;
                        end else begin
                            for (int i = 0; i < int'(m_len); i++) begin
                                q.push_back('{c_RD_OP,  m_src + 32'(4 * i)});
                                q.push_back('{c_GAP_OP, 32'h0});
                                q.push_back('{c_WR_OP,  m_dst + 32'(4 * i)});
                            end
                        end
                    end
                endcase
            end
            m_streak = (r && !g) ? ((m_streak < c_LIMIT) ? m_streak + 1 : m_streak) : 0;
            m_irq = nirq;
        end
    end

    // Per-cycle comparison and event counters
    logic chk_en = 1'b0;
    int   dma_cycles = 0, irq_cnt = 0, busy_cnt = 0, stall_cnt = 0;

    always @(negedge clk) begin
        logic        g;
        logic [31:0] ea, ed;
        logic [3:0]  ew;
        if (chk_en) begin
            g = m_gnt();
            chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && g));
            if (g) begin
                ea = q[0].addr;
                ed = m_buf;
                ew = (q[0].kind == c_WR_OP) ? 4'hF : 4'h0;
            end else begin
                ea = cpu_addr;
                ed = cpu_wdata;
                ew = cpu_wenable;
            end
            chk("bus_addr", bus_addr, ea);
            chk("bus_wenable", 32'(bus_wenable), 32'(ew));
            if (!(g && q[0].kind == c_RD_OP)) chk("bus_wdata", bus_wdata, ed);
            chk("dma_irq", 32'(dma_irq), 32'(m_irq));
            if (cfg_addr == 2'd3)
                chk("ctrl_read", cfg_rdata, {30'd0, m_done, q.size() != 0});
            if (bus_addr !== cpu_addr || bus_wenable !== cpu_wenable) dma_cycles++;
            if (dma_irq) irq_cnt++;
            if (cpu_stall) stall_cnt++;
            if (cfg_addr == 2'd3 && cfg_rdata[0]) busy_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_wenable = 1'b1; cfg_addr = a; cfg_wdata = d;
        cyc();
        cfg_wenable = 1'b0; cfg_addr = 2'd3; cfg_wdata = 32'h0;
    endtask

    task automatic cfg_read(input string name, input logic [1:0] a, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        chk(name, cfg_rdata, exp);
        cfg_addr = 2'd3;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!cfg_rdata[0]) break;
            cyc();
        end
        if (cfg_rdata[0]) chk("wait_idle_timeout", 32'(cfg_rdata[0]), 32'h0);
        cyc();
    endtask

    int d0, i0, b0, s0;

    task automatic snap();
        d0 = dma_cycles; i0 = irq_cnt; b0 = busy_cnt; s0 = stall_cnt;
    endtask

    initial begin
        rst = 1'b1; cpu_req = 0; cpu_addr = 32'h0000_0F00; cpu_wdata = 0; cpu_wenable = 0;
        cfg_wenable = 0; cfg_addr = 2'd3; cfg_wdata = 0;
        cyc(); cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        chk("reset_ctrl", cfg_rdata, 32'h0);
        chk("reset_stall", 32'(cpu_stall), 32'h0);
        chk("reset_irq", 32'(dma_irq), 32'h0);
        cfg_read("reset_src", 2'd0, 32'h0);
        cfg_read("reset_len", 2'd2, 32'h0);

        // Idle passthrough
        cpu_req = 1; cpu_addr = 32'h4000_0010; cpu_wdata = 32'hAB; cpu_wenable = 4'b0001;
        cyc(); cyc(); cyc();
        chk("pass_addr", bus_addr, 32'h4000_0010);
        chk("pass_wdata", bus_wdata, 32'h0000_00AB);
        chk("pass_wen", 32'(bus_wenable), 32'h1);
        cpu_req = 0; cpu_addr = 32'h0000_0F00; cpu_wdata = 0; cpu_wenable = 0;

        // Uncontended copy of three words
        cfg_write(2'd0, 32'h0000_0103);
        cfg_write(2'd1, 32'h4000_0000);
        cfg_write(2'd2, 32'd3);
        snap();
        cfg_write(2'd3, 32'h1);
        wait_idle(40);
        chk("copy_busy_cycles", 32'(busy_cnt - b0), 32'd9);
        chk("copy_irq_pulses", 32'(irq_cnt - i0), 32'd1);
        chk("copy_dma_cycles", 32'(dma_cycles - d0), 32'd6);
        chk("copy_word0", mem[0], 32'h5A00_0040);
        chk("copy_word1", mem[1], 32'h5A00_0041);
        chk("copy_word2", mem[2], 32'h5A00_0042);
        cfg_read("copy_ctrl", 2'd3, 32'h2);
        cfg_read("copy_src_ptr", 2'd0, 32'h0000_010C);
        cfg_read("copy_dst_ptr", 2'd1, 32'h4000_000C);
        cfg_read("copy_count", 2'd2, 32'h0);

        // Contention: CPU loads held throughout a two-word copy
        cfg_write(2'd1, 32'h4000_0040);
        cfg_write(2'd2, 32'd2);
        cpu_req = 1; cpu_addr = 32'h0000_0800;
        snap();
        cfg_write(2'd3, 32'h1);
        wait_idle(60);
        cpu_req = 0; cpu_addr = 32'h0000_0F00;
        chk("cont_busy_cycles", 32'(busy_cnt - b0), 32'd22);
        chk("cont_stalls", 32'(stall_cnt - s0), 32'd4);
        chk("cont_word0", mem[16], 32'h5A00_0040);
        chk("cont_word1", mem[17], 32'h5A00_0041);

        // CPU store to the source word during the capture cycle
        cfg_write(2'd0, 32'h0000_0180);
        cfg_write(2'd1, 32'h4000_0080);
        cfg_write(2'd2, 32'd1);
        cfg_write(2'd3, 32'h1);
        cyc();
        cpu_req = 1; cpu_addr = 32'h0000_0180; cpu_wdata = 32'h1234_5678; cpu_wenable = 4'hF;
        cyc();
        cpu_req = 0; cpu_addr = 32'h0000_0F00; cpu_wdata = 0; cpu_wenable = 0;
        wait_idle(20);
        chk("cap_dma_data", mem[32], 32'h5A00_0060);
        chk("cap_cpu_store", mem[96], 32'h1234_5678);

        // Zero-length start
        cfg_write(2'd2, 32'd0);
        snap();
        cfg_write(2'd3, 32'h1);
        cyc(); cyc();
        chk("len0_dma_cycles", 32'(dma_cycles - d0), 32'd0);
        chk("len0_irq_pulses", 32'(irq_cnt - i0), 32'd1);
        cfg_read("len0_done", 2'd3, 32'h2);
        cfg_write(2'd3, 32'h0);
        cfg_read("len0_cleared", 2'd3, 32'h0);

        // Writes while busy are ignored
        cfg_write(2'd0, 32'h0000_0200);
        cfg_write(2'd1, 32'h0000_0300);
        cfg_write(2'd2, 32'd2);
        snap();
        cfg_write(2'd3, 32'h1);
        cyc();
        cfg_write(2'd0, 32'h0000_FFF0);
        cfg_write(2'd3, 32'h1);
        wait_idle(40);
        chk("busy_irq_pulses", 32'(irq_cnt - i0), 32'd1);
        cfg_read("busy_src_ptr", 2'd0, 32'h0000_0208);
        chk("busy_word0", mem[192], 32'h5A00_0080);
        chk("busy_word1", mem[193], 32'h5A00_0081);
        cfg_write(2'd1, 32'h0000_0340);
        cfg_write(2'd2, 32'd1);
        cfg_write(2'd3, 32'h1);
        wait_idle(20);
        chk("busy_src_kept", mem[208], 32'h5A00_0080);

        // Reset mid-transfer
        cfg_write(2'd1, 32'h0000_0380);
        cfg_write(2'd2, 32'd4);
        cfg_write(2'd3, 32'h1);
        cyc(); cyc(); cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        snap();
        chk("rst_ctrl", cfg_rdata, 32'h0);
        cfg_read("rst_src_ptr", 2'd0, 32'h0);
        repeat (10) cyc();
        chk("rst_dma_cycles", 32'(dma_cycles - d0), 32'd0);
        chk("rst_irq_pulses", 32'(irq_cnt - i0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
